// File: rtl/map_port_arbiter.sv
// Shares the single map-RAM port between N_REQ read probes and one brick-write port.
// Writes win unless the previous issue was also a write and a read is waiting.
module map_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int COORD_W = 5,
    parameter int TILE_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*COORD_W-1:0]   req_x,
    input  logic [N_REQ*COORD_W-1:0]   req_y,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rsp_valid,
    output logic [TILE_W-1:0]          rsp_tile,
    input  logic                       wr_req,
    input  logic [COORD_W-1:0]         wr_x,
    input  logic [COORD_W-1:0]         wr_y,
    input  logic [TILE_W-1:0]          wr_tile,
    output logic                       wr_ack,
    output logic [COORD_W-1:0]         mem_x,
    output logic [COORD_W-1:0]         mem_y,
    output logic                       mem_we,
    output logic [TILE_W-1:0]          mem_wdata,
    input  logic [TILE_W-1:0]          mem_rdata
);

    localparam int PTR_W = $clog2(N_REQ);

    // Handshake: req/wr_req are levels held with their address until the one-cycle
    // gnt/wr_ack pulse; the pulse masks that requester for one decision so it can drop.
    logic [N_REQ-1:0]   rd_cand;
    logic               wr_cand;
    logic               rd_found;
    logic [PTR_W-1:0]   rd_idx;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic               wr_win;
    logic               rd_win;
    logic [PTR_W-1:0]   rr_ptr;
    logic               last_wr;
    int                 j;

    always_comb begin
        rd_cand  = req & ~gnt;
        wr_cand  = wr_req & ~wr_ack;
        rd_found = 1'b0;
        rd_idx   = '0;
        sel_x    = '0;
        sel_y    = '0;
        j        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!rd_found && rd_cand[j]) begin
                rd_found = 1'b1;
                rd_idx   = PTR_W'(j);
                sel_x    = req_x[j*COORD_W +: COORD_W];
                sel_y    = req_y[j*COORD_W +: COORD_W];
            end
        end
        wr_win = en && wr_cand && (!last_wr || (rd_cand == '0));
        rd_win = en && !wr_win && rd_found;
    end

    assign rsp_tile = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            rsp_valid <= '0;
            wr_ack    <= 1'b0;
            mem_we    <= 1'b0;
            mem_x     <= '0;
            mem_y     <= '0;
            mem_wdata <= '0;
            rr_ptr    <= '0;
            last_wr   <= 1'b0;
        end else begin
            // Write cycles carry gnt=0, so they never produce a response.
            rsp_valid <= gnt;
            gnt       <= '0;
            wr_ack    <= 1'b0;
            mem_we    <= 1'b0;
            if (wr_win) begin
                wr_ack    <= 1'b1;
                mem_we    <= 1'b1;
                mem_x     <= wr_x;
                mem_y     <= wr_y;
                mem_wdata <= wr_tile;
                last_wr   <= 1'b1;
            end else if (rd_win) begin
                gnt     <= N_REQ'(1) << rd_idx;
                mem_x   <= sel_x;
                mem_y   <= sel_y;
                rr_ptr  <= (rd_idx == PTR_W'(N_REQ - 1)) ? '0 : rd_idx + PTR_W'(1);
                last_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Bench for map_port_arbiter: behavioural map RAM, response scoreboard,
// table-driven single reads and hand-written multi-cycle sequences.
module tb_map_port_arbiter;

    localparam int N_REQ   = 4;
    localparam int COORD_W = 5;
    localparam int TILE_W  = 2;
    localparam int W       = N_REQ + TILE_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*COORD_W-1:0] req_x;
    logic [N_REQ*COORD_W-1:0] req_y;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         rsp_valid;
    logic [TILE_W-1:0]        rsp_tile;
    logic                     wr_req;
    logic [COORD_W-1:0]       wr_x;
    logic [COORD_W-1:0]       wr_y;
    logic [TILE_W-1:0]        wr_tile;
    logic                     wr_ack;
    logic [COORD_W-1:0]       mem_x;
    logic [COORD_W-1:0]       mem_y;
    logic                     mem_we;
    logic [TILE_W-1:0]        mem_wdata;
    logic [TILE_W-1:0]        mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    logic [TILE_W-1:0] map     [32][32];
    logic [TILE_W-1:0] ref_map [32][32];

    map_port_arbiter #(.N_REQ(N_REQ), .COORD_W(COORD_W), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_tile(rsp_tile),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_tile(wr_tile), .wr_ack(wr_ack),
        .mem_x(mem_x), .mem_y(mem_y), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [TILE_W-1:0] init_tile(input int x, input int y);
        if (x == 3 && y == 5)  return 2'd2;
        if (x == 4 && y == 4)  return 2'd1;
        if (x == 7 && y == 1)  return 2'd3;
        if (x == 0 && y == 31) return 2'd2;
        if (x == 31 && y == 0) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- map RAM model (1-cycle read, sync write) ----------------
    initial begin
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                map[x][y] = init_tile(x, y);
        forever begin
            @(posedge clk);
            mem_rdata <= map[mem_x][mem_y];
            if (mem_we) map[mem_x][mem_y] = mem_wdata;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic                     prst;
        logic [N_REQ*COORD_W-1:0] px, py;
        logic [COORD_W-1:0]       pwx, pwy, ex, ey;
        logic [TILE_W-1:0]        pwt;
        logic [W-1:0]             e;
        int                       gi;
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                ref_map[x][y] = init_tile(x, y);
        forever begin
            @(posedge clk);
            prst = rst; px = req_x; py = req_y; pwx = wr_x; pwy = wr_y; pwt = wr_tile;
            #1;
            if (prst) begin
                exp_q.delete();
            end else begin
                if (rsp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected_rsp", 32'(rsp_valid), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_rsp", 32'({rsp_valid, rsp_tile}), 32'(e));
                    end
                end
                if (gnt != '0) begin
                    chk("gnt_onehot", 32'($countones(gnt)), 32'(1));
                    gi = 0;
                    for (int i = 0; i < N_REQ; i++) if (gnt[i]) gi = i;
                    ex = px[gi*COORD_W +: COORD_W];
                    ey = py[gi*COORD_W +: COORD_W];
                    chk("rd_addr", 32'({mem_x, mem_y, mem_we, wr_ack}), 32'({ex, ey, 2'b00}));
                    exp_q.push_back({gnt, ref_map[ex][ey]});
                end
                if (wr_ack) begin
                    chk("wr_issue", 32'({mem_we, mem_x, mem_y, mem_wdata, gnt}),
                        32'({1'b1, pwx, pwy, pwt, {N_REQ{1'b0}}}));
                    ref_map[pwx][pwy] = pwt;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        req_x[i*COORD_W +: COORD_W] = x;
        req_y[i*COORD_W +: COORD_W] = y;
    endtask

    typedef struct {
        int                 id;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [TILE_W-1:0]  tile;
    } vec_t;

    vec_t vt[5];
    logic [N_REQ-1:0] last_drop;

    initial begin
        vt[0] = '{0, 5'd3,  5'd5,  2'd2};
        vt[1] = '{2, 5'd7,  5'd1,  2'd3};
        vt[2] = '{3, 5'd0,  5'd31, 2'd2};
        vt[3] = '{1, 5'd31, 5'd0,  2'd1};
        vt[4] = '{1, 5'd4,  5'd4,  2'd1};

        rst = 1'b1; en = 1'b1; req = '0; req_x = '0; req_y = '0;
        wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_tile = '0;
        step(); step();
        chk("rst_gnt",   32'(gnt), 32'(0));
        chk("rst_rsp",   32'(rsp_valid), 32'(0));
        chk("rst_wr",    32'({wr_ack, mem_we}), 32'(0));
        chk("rst_addr",  32'({mem_x, mem_y, mem_wdata}), 32'(0));
        rst = 1'b0;

        // Single reads from the vector table.
        foreach (vt[v]) begin
            set_addr(vt[v].id, vt[v].x, vt[v].y);
            req = N_REQ'(1) << vt[v].id;
            step();
            chk("vec_gnt",  32'(gnt), 32'(1) << vt[v].id);
            chk("vec_addr", 32'({mem_x, mem_y, mem_we}), 32'({vt[v].x, vt[v].y, 1'b0}));
            req = '0;
            step();
            chk("vec_rsp",  32'({rsp_valid, rsp_tile}), 32'({N_REQ'(1) << vt[v].id, vt[v].tile}));
            step();
        end

        // Round robin from rr_ptr=0 with drop-and-reraise requesters.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_addr(i, COORD_W'(i), COORD_W'(i + 10));
        req = '1; last_drop = '0;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(1) << (k % N_REQ));
            req = (req | last_drop) & ~gnt;
            last_drop = gnt;
        end
        req = '0; step(); step(); step();

        // Write beats a pending read, then read-after-write sees the new tile.
        wr_x = 5'd4; wr_y = 5'd4; wr_tile = 2'd0; wr_req = 1'b1;
        set_addr(1, 5'd4, 5'd4); req = 4'b0010;
        step();
        chk("wp_ack", 32'({wr_ack, mem_we, gnt}), 32'({2'b11, 4'b0000}));
        chk("wp_addr", 32'({mem_x, mem_y, mem_wdata}), 32'({5'd4, 5'd4, 2'd0}));
        wr_req = 1'b0;
        step();
        chk("wp_gnt", 32'({gnt, mem_we}), 32'({4'b0010, 1'b0}));
        req = '0;
        step();
        chk("raw_rsp", 32'({rsp_valid, rsp_tile}), 32'({4'b0010, 2'd0}));
        step();

        // Continuous write + read pending: strict 1:1 alternation starting with the write.
        wr_x = 5'd9; wr_y = 5'd9; wr_req = 1'b1;
        set_addr(0, 5'd9, 5'd9); req = 4'b0001;
        for (int m = 0; m < 8; m++) begin
            wr_tile = TILE_W'(m);
            step();
            if (m % 2 == 0) chk("alt_wr", 32'({wr_ack, gnt}), 32'({1'b1, 4'b0000}));
            else            chk("alt_rd", 32'({wr_ack, gnt}), 32'({1'b0, 4'b0001}));
            if (m % 2 == 0 && m >= 2)
                chk("alt_rsp", 32'({rsp_valid, rsp_tile}), 32'({4'b0001, TILE_W'(m - 2)}));
        end
        wr_req = 1'b0; req = '0;
        step();
        chk("alt_rsp_last", 32'({rsp_valid, rsp_tile}), 32'({4'b0001, 2'd2}));
        step();

        // Enable gating: nothing issues, address held, resume from saved pointer (1).
        en = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_addr(i, COORD_W'(i), COORD_W'(i + 10));
        req = '1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("en_off", 32'({gnt, wr_ack, mem_we, mem_x, mem_y}), 32'({6'b0, 5'd9, 5'd9}));
        end
        en = 1'b1;
        step();
        chk("en_resume", 32'(gnt), 32'(4'b0010));
        en = 1'b0; req = '0;
        step();
        chk("en_fall_rsp", 32'(rsp_valid), 32'(4'b0010));
        en = 1'b1;
        step();

        // Reset while a read is in flight: its response is dropped.
        set_addr(2, 5'd6, 5'd6); req = 4'b0100;
        step();
        chk("mid_gnt", 32'(gnt), 32'(4'b0100));
        rst = 1'b1; req = '0;
        step();
        chk("mid_rst_rsp", 32'({rsp_valid, gnt, wr_ack, mem_we}), 32'(0));
        chk("mid_rst_addr", 32'({mem_x, mem_y, mem_wdata}), 32'(0));
        rst = 1'b0; req = '1;
        step();
        chk("mid_first_gnt", 32'(gnt), 32'(4'b0001));
        req = '0;
        step(); step(); step();

        chk("sb_drain", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
